// File: rtl/cache_fill_if.sv
// Pipeline/memory-side signal bundle for the cache fill controller.
// The fill controller uses the slave view; a pipeline or bench model uses master.
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] write_word_addr;
  logic        write_tag_array;
  logic [15:0] miss_count;

  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, memory_enable, memory_address,
           write_data_array, write_word_addr, write_tag_array, miss_count
  );

  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, memory_enable, memory_address,
           write_data_array, write_word_addr, write_tag_array, miss_count
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, issues 8 word reads for the 16-byte block
// and writes each returned word into the data array, tagging the line on the last one.
//
// state | meaning
// IDLE  | no fill in progress; a miss starts one
// FILL  | issuing reads and accepting returned words for the latched block
module cache_fill_fsm (
  input logic       clk,
  input logic       rst,
  cache_fill_if.slave bus
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state, state_nxt;
  logic [3:0]  issue_cnt, issue_cnt_nxt;
  logic [3:0]  recv_cnt, recv_cnt_nxt;
  logic [11:0] base_blk, base_blk_nxt;
  logic [15:0] miss_count, miss_count_nxt;
  logic [2:0]  issue_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= 4'd0;
      recv_cnt   <= 4'd0;
      base_blk   <= 12'd0;
      miss_count <= 16'd0;
    end else begin
      state      <= state_nxt;
      issue_cnt  <= issue_cnt_nxt;
      recv_cnt   <= recv_cnt_nxt;
      base_blk   <= base_blk_nxt;
      miss_count <= miss_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    issue_cnt_nxt  = issue_cnt;
    recv_cnt_nxt   = recv_cnt;
    base_blk_nxt   = base_blk;
    miss_count_nxt = miss_count;

    bus.fsm_busy         = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;

    // Once all 8 reads are issued the address parks on the last word of the
    // block; building addresses by concatenation keeps them inside the block.
    issue_idx           = issue_cnt[3] ? 3'd7 : issue_cnt[2:0];
    bus.memory_address  = {base_blk, issue_idx, 1'b0};
    bus.write_word_addr = {base_blk, recv_cnt[2:0], 1'b0};
    bus.miss_count      = miss_count;

    case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          bus.fsm_busy  = 1'b1;
          state_nxt     = FILL;
          base_blk_nxt  = bus.miss_address[15:4];
          issue_cnt_nxt = 4'd0;
          recv_cnt_nxt  = 4'd0;
        end
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        if (!issue_cnt[3]) begin
          bus.memory_enable = 1'b1;
          issue_cnt_nxt     = issue_cnt + 4'd1;
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          recv_cnt_nxt         = recv_cnt + 4'd1;
          if (recv_cnt == 4'd7) begin
            bus.write_tag_array = 1'b1;
            state_nxt           = IDLE;
            if (miss_count != 16'hFFFF)
              miss_count_nxt = miss_count + 16'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
